alu_arbiter: RTL

- Shares the single integer ALU between two requesters: port 0 is the execute stage, port 1 is the branch/address-generation unit.
- Each port uses a valid/ready request handshake and a valid/ready response handshake.
- Round-robin arbitration; the ALU result is captured into a per-port single-entry response buffer, giving a fixed 1-cycle latency.
- Drives the ALU operand/control inputs and consumes alu_out; it contains no arithmetic itself.

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one integer ALU between two requesters, with a
// registered single-entry response buffer per port. Optional grant lock: ALU_ARB_LOCK_EN.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_ra,
    input  logic [WIDTH-1:0] r0_rb,
    input  logic             r0_sel_logic,
    input  logic [1:0]       r0_op,
    input  logic             r0_lock,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_rsp_data,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_ra,
    input  logic [WIDTH-1:0] r1_rb,
    input  logic             r1_sel_logic,
    input  logic [1:0]       r1_op,
    input  logic             r1_lock,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_rsp_data,

    output logic [WIDTH-1:0] alu_ra,
    output logic [WIDTH-1:0] alu_rb,
    output logic             alu_sel_logic,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int unsigned OP_W = 2;

    logic last_grant;
    logic space0, space1;
    logic elig0, elig1;
    logic allow0, allow1;
    logic grant0, grant1;

    assign space0 = !r0_rsp_valid || r0_rsp_ready;
    assign space1 = !r1_rsp_valid || r1_rsp_ready;

`ifdef ALU_ARB_LOCK_EN
    logic lock_active;
    logic lock_owner;

    // While locked only the owner may compete, even if it is idle or stalled.
    assign allow0 = !lock_active || (lock_owner == 1'b0);
    assign allow1 = !lock_active || (lock_owner == 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
        end else if (grant0) begin
            if (r0_lock) begin
                lock_active <= 1'b1;
                lock_owner  <= 1'b0;
            end else if (lock_active && (lock_owner == 1'b0)) begin
                lock_active <= 1'b0;
            end
        end else if (grant1) begin
            if (r1_lock) begin
                lock_active <= 1'b1;
                lock_owner  <= 1'b1;
            end else if (lock_active && (lock_owner == 1'b1)) begin
                lock_active <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;

    assign unused_lock = r0_lock ^ r1_lock;
    assign allow0      = 1'b1;
    assign allow1      = 1'b1;
`endif

    assign elig0 = r0_valid && space0 && allow0;
    assign elig1 = r1_valid && space1 && allow1;

    // On contention the port that did not win last time is granted.
    assign grant0 = elig0 && (!elig1 || (last_grant == 1'b1));
    assign grant1 = elig1 && (!elig0 || (last_grant == 1'b0));

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // Port 0 operands are the idle default so the ALU inputs never float.
    always_comb begin
        alu_ra        = r0_ra;
        alu_rb        = r0_rb;
        alu_sel_logic = r0_sel_logic;
        alu_op        = r0_op;
        if (grant1) begin
            alu_ra        = r1_ra;
            alu_rb        = r1_rb;
            alu_sel_logic = r1_sel_logic;
            alu_op        = OP_W'(r1_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Response buffers: refill on accept, otherwise drain when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rsp_valid <= 1'b0;
            r0_rsp_data  <= '0;
        end else if (grant0) begin
            r0_rsp_valid <= 1'b1;
            r0_rsp_data  <= alu_out;
        end else if (r0_rsp_valid && r0_rsp_ready) begin
            r0_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_rsp_valid <= 1'b0;
            r1_rsp_data  <= '0;
        end else if (grant1) begin
            r1_rsp_valid <= 1'b1;
            r1_rsp_data  <= alu_out;
        end else if (r1_rsp_valid && r1_rsp_ready) begin
            r1_rsp_valid <= 1'b0;
        end
    end

endmodule
